fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 113 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the FIFO write arbiter: default parameter
//   values, burst counter width and the arbiter state encoding.
package fifo_arb_pkg;

    localparam int unsigned NUM_REQ_DEF    = 4;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned MAX_BURST_DEF  = 4;
    // Wide enough for MAX_BURST up to 15.
    localparam int unsigned BURST_CNT_W    = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Returns the first set bit of req
//   found by scanning upward from index start, wrapping at N-1 -> 0.
// Ports:
//   req   : request vector, one bit per requester
//   start : index the scan begins at
//   found : at least one request bit is set
//   idx   : index of the winning request (0 when found is low)
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((32'(start) + i) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Grants one of NUM_REQ write requesters exclusive access to a FIFO for
//   a burst of up to MAX_BURST words. Owners are chosen round-robin,
//   starting one past the previous owner. One IDLE cycle separates bursts.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : per-requester word available
//   req_data      : per-requester word, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     : per-requester word accepted (when ANDed with req_valid)
//   fifo_w_en     : FIFO write enable
//   fifo_data_in  : FIFO write data (0 when no burst is active)
//   fifo_full     : FIFO full flag
//   grant_valid   : a burst grant is active
//   grant_id      : current owner in a burst, last owner otherwise
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    arb_state_t             state, next_state;
    logic [IW-1:0]          owner;
    logic [IW-1:0]          last_owner;
    logic [BURST_CNT_W-1:0] count;
    logic [IW-1:0]          start_idx;
    logic                   pick_found;
    logic [IW-1:0]          pick_idx;

    assign start_idx = (last_owner == IW'(NUM_REQ - 1)) ? '0 : last_owner + 1'b1;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req   (req_valid),
        .start (start_idx),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Outputs are forced idle while rst is high so an in-flight burst
    // cannot write during the reset cycle, even though state only
    // clears at the edge.
    always_comb begin
        next_state   = state;
        req_ready    = '0;
        fifo_w_en    = 1'b0;
        fifo_data_in = '0;
        grant_valid  = 1'b0;
        grant_id     = last_owner;
        if (rst) begin
            next_state = IDLE;
            grant_id   = IW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) next_state = BURST;
                end
                BURST: begin
                    grant_valid      = 1'b1;
                    grant_id         = owner;
                    req_ready[owner] = !fifo_full;
                    fifo_w_en        = req_valid[owner] && !fifo_full;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (IW'(i) == owner) fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                    if (!req_valid[owner]) begin
                        next_state = IDLE;
                    end else if (fifo_w_en && count == BURST_CNT_W'(MAX_BURST - 1)) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            owner      <= '0;
            last_owner <= IW'(NUM_REQ - 1);
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                if (pick_found) begin
                    owner <= pick_idx;
                    count <= '0;
                end
            end else begin
                if (fifo_w_en) count <= count + 1'b1;
                if (next_state == IDLE) last_owner <= owner;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a transaction-level reference model of the arbiter.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_w_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full;
    logic           grant_valid;
    logic [1:0]     grant_id;

    logic [W-1:0]   dat [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_data
        assign req_data[g*W +: W] = dat[g];
    end

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (W),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_w_en    (fifo_w_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a grant session (busy/owner/words taken) plus the
    // previous owner; each requester sends a numbered word stream.
    bit         m_busy;
    logic [1:0] m_owner;
    logic [1:0] m_last;
    int         m_words;
    int         seq  [N];
    int         base [N];
    bit         last_wen;
    int         n_w2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [N-1:0] e_rdy;
        logic         e_wen;
        logic         e_gv;
        logic [1:0]   e_gid;
        logic [W-1:0] e_dat;
        logic [1:0]   c;
        bit           hit;
        for (int i = 0; i < N; i++) dat[i] = W'(base[i] + seq[i]);
        @(negedge clk);
        e_rdy = '0;
        e_wen = 1'b0;
        e_gv  = 1'b0;
        e_dat = '0;
        e_gid = m_last;
        if (rst) begin
            e_gid = 2'(N - 1);
        end else if (m_busy) begin
            e_gv           = 1'b1;
            e_gid          = m_owner;
            e_rdy[m_owner] = !fifo_full;
            e_wen          = req_valid[m_owner] && !fifo_full;
            e_dat          = dat[m_owner];
        end
        chk("req_ready",    32'(req_ready),    32'(e_rdy));
        chk("fifo_w_en",    32'(fifo_w_en),    32'(e_wen));
        chk("fifo_data_in", 32'(fifo_data_in), 32'(e_dat));
        chk("grant_valid",  32'(grant_valid),  32'(e_gv));
        chk("grant_id",     32'(grant_id),     32'(e_gid));
        last_wen = e_wen;
        if (fifo_w_en && grant_id == 2'd2) n_w2++;
        if (rst) begin
            m_busy  = 1'b0;
            m_owner = '0;
            m_last  = 2'(N - 1);
            m_words = 0;
        end else if (!m_busy) begin
            hit = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = 2'((32'(m_last) + 32'(k)) % N);
                if (!hit && req_valid[c]) begin
                    hit     = 1'b1;
                    m_busy  = 1'b1;
                    m_owner = c;
                    m_words = 0;
                end
            end
        end else if (!req_valid[m_owner]) begin
            m_busy = 1'b0;
            m_last = m_owner;
        end else if (e_wen) begin
            seq[m_owner]++;
            m_words++;
            if (m_words == MB) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int left;
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        m_busy    = 1'b0;
        m_owner   = '0;
        m_last    = 2'(N - 1);
        m_words   = 0;
        last_wen  = 1'b0;
        n_w2      = 0;
        for (int i = 0; i < N; i++) begin
            seq[i]  = 0;
            base[i] = int'($urandom_range(0, 255));
        end

        // Reset state
        cycle();
        cycle();
        rst = 1'b0;

        // All requesters busy: owners 0,1,2,3,0 with 4 words each
        req_valid = 4'b1111;
        for (int i = 0; i < 25; i++) cycle();

        // Only requester 2 with 10 queued words: bursts 4,4,2
        req_valid = '0;
        do_reset();
        left = 10;
        n_w2 = 0;
        for (int i = 0; i < 20; i++) begin
            req_valid = (left > 0) ? 4'b0100 : 4'b0000;
            cycle();
            if (last_wen) left--;
        end
        chk("s2_words_owner2", 32'(n_w2), 32'd10);
        chk("s2_left",         32'(left), 32'd0);

        // Owner 1 stalled by fifo_full at count 2, then finishes
        req_valid = '0;
        do_reset();
        req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) cycle();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Owner 0 drops after one word; next grant goes to 1
        req_valid = '0;
        do_reset();
        req_valid = 4'b0001;
        cycle();
        cycle();
        req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) cycle();

        // Reset mid-burst at count 3, then reqs 1 and 3 -> grant to 1
        req_valid = '0;
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) cycle();
        req_valid = 4'b1010;
        do_reset();
        cycle();
        chk("s5_grant_id",    32'(grant_id),    32'd1);
        chk("s5_grant_valid", 32'(grant_valid), 32'd1);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = N'($urandom);
            fifo_full = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
